// File: rtl/mux_sched_pkg.sv
// ============================================================================
// Module : mux_sched_pkg
// Brief  : Shared constants, FSM state encoding and helpers for mux_sched_4.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_sched_pkg;

  localparam int N_REQ    = 4;
  localparam int SEL_W    = 2;
  localparam int TENURE_W = 8;
  localparam int DATA_W   = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] oneHot(input logic [SEL_W-1:0] idx);
    oneHot      = '0;
    oneHot[idx] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module : rr_pick4
// Brief  : Combinational 4-way round-robin picker; scans upward from
//          last_owner+1 with wrap and reports the first set request.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick4
  import mux_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_owner,
  output logic             any,
  output logic [SEL_W-1:0] winner
);

  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  // The final iteration lands back on last_owner, so it only wins when alone.
  always_comb begin
    any     = |req;
    winner  = last_owner;
    w_found = 1'b0;
    w_idx   = last_owner;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = last_owner + SEL_W'(k);
      if (!w_found && req[w_idx]) begin
        winner  = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_sched_4.sv
// ============================================================================
// Module : mux_sched_4
// Brief  : 4-requester round-robin arbiter with registered grant/select and
//          one-cycle-latency data mux of the current owner.
//          Optional macro ARB_TIMEOUT_EN bounds owner tenure to MAX_TENURE.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_sched_4
  import mux_sched_pkg::*;
#(
  parameter int MAX_TENURE = 8
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [N_REQ-1:0]  grant,
  output logic [SEL_W-1:0]  select,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  if ((MAX_TENURE < 2) || (MAX_TENURE > (1 << TENURE_W) - 1)) begin : g_badTenure
    $error("mux_sched_4: MAX_TENURE out of range 2..255");
  end

  state_t             r_state;
  state_t             w_nextState;
  logic [N_REQ-1:0]   r_grant;
  logic [SEL_W-1:0]   r_select;
  logic [SEL_W-1:0]   w_nextSelect;
  logic [SEL_W-1:0]   r_lastOwner;
  logic [DATA_W-1:0]  r_dout;
  logic               r_doutValid;
  logic               w_any;
  logic [SEL_W-1:0]   w_winner;
  logic               w_take;
  logic               w_timeout;
  logic               w_dataLoad;
  logic [DATA_W-1:0]  w_ownerData;

  rr_pick4 u_pick (
    .req        (req),
    .last_owner (r_lastOwner),
    .any        (w_any),
    .winner     (w_winner)
  );

`ifdef ARB_TIMEOUT_EN
  logic [TENURE_W-1:0] r_tenure;
  localparam logic [TENURE_W-1:0] TENURE_LAST = TENURE_W'(MAX_TENURE - 1);

  assign w_timeout = (r_tenure == TENURE_LAST) && |(req & ~r_grant);

  // Cleared whenever ownership moves or the arbiter idles; saturates otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tenure <= '0;
    end else if (w_take || (w_nextState == IDLE)) begin
      r_tenure <= '0;
    end else if ((r_state == GRANT) && (r_tenure != TENURE_LAST)) begin
      r_tenure <= r_tenure + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_nextState  = r_state;
    w_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_nextState = GRANT;
          w_take      = 1'b1;
        end
      end
      GRANT: begin
        if (!req[r_select]) begin
          if (w_any) begin
            w_take = 1'b1;
          end else begin
            w_nextState = IDLE;
          end
        end else if (w_timeout) begin
          w_take = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
    w_nextSelect = w_take ? w_winner : r_select;
  end

  always_comb begin
    case (r_select)
      2'd0:    w_ownerData = din0;
      2'd1:    w_ownerData = din1;
      2'd2:    w_ownerData = din2;
      default: w_ownerData = din3;
    endcase
  end

  assign w_dataLoad = |(r_grant & req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_select    <= '0;
      r_lastOwner <= SEL_W'(N_REQ - 1);
      r_dout      <= '0;
      r_doutValid <= 1'b0;
    end else begin
      r_state  <= w_nextState;
      r_grant  <= (w_nextState == GRANT) ? oneHot(w_nextSelect) : '0;
      r_select <= w_nextSelect;
      if (w_take) begin
        r_lastOwner <= w_winner;
      end
      if (w_dataLoad) begin
        r_dout      <= w_ownerData;
        r_doutValid <= 1'b1;
      end else begin
        r_doutValid <= 1'b0;
      end
    end
  end

  assign grant      = r_grant;
  assign select     = r_select;
  assign dout       = r_dout;
  assign dout_valid = r_doutValid;

endmodule

`default_nettype wire

// File: tb/tb_mux_sched_4.sv
// ============================================================================
// Module : tb_mux_sched_4
// Brief  : Self-checking bench for mux_sched_4 (honours ARB_TIMEOUT_EN).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_sched_4;

  localparam int MAXT = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din0, din1, din2, din3;
  logic [3:0] grant;
  logic [1:0] select;
  logic [3:0] dout;
  logic       dout_valid;

  int nChecks = 0;
  int nFails  = 0;

  mux_sched_4 #(.MAX_TENURE(MAXT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .grant      (grant),
    .select     (select),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = idle), rotation pointer, tenure, data.
  int         mOwner, mLast, mTen, mNext;
  logic [3:0] mDout;
  logic       mValid;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic int nextOwner(input logic [3:0] r, input int owner, input int last, input int ten);
    if (owner < 0 || !r[owner]) return pick(r, last);
`ifdef ARB_TIMEOUT_EN
    if (ten == MAXT - 1 && (r & ~(4'b0001 << owner)) != 4'b0000) return pick(r, last);
`endif
    return owner;
  endfunction

  function automatic logic [3:0] dinOf(input int i);
    case (i)
      0:       return din0;
      1:       return din1;
      2:       return din2;
      default: return din3;
    endcase
  endfunction

  function automatic logic [3:0] grantOf(input int o);
    logic [3:0] g;
    g = 4'b0000;
    if (o >= 0) g[o] = 1'b1;
    return g;
  endfunction

  always_comb mNext = nextOwner(req, mOwner, mLast, mTen);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner <= -1;
      mLast  <= 3;
      mTen   <= 0;
      mDout  <= 4'h0;
      mValid <= 1'b0;
    end else begin
      mOwner <= mNext;
      if (mNext >= 0 && mNext != mOwner) mLast <= mNext;
      mTen <= (mNext < 0 || mNext != mOwner) ? 0 : ((mTen < MAXT - 1) ? mTen + 1 : mTen);
      if (mOwner >= 0 && req[mOwner]) begin
        mDout  <= dinOf(mOwner);
        mValid <= 1'b1;
      end else begin
        mValid <= 1'b0;
      end
    end
  end

  bit started = 1'b0;

  always @(negedge clk) begin
    if (started && rst_n) begin
      check("grant_model", 32'(grant), 32'(grantOf(mOwner)));
      if (mOwner >= 0) check("select_model", 32'(select), 32'(mOwner));
      check("dout_valid_model", 32'(dout_valid), 32'(mValid));
      check("dout_model", 32'(dout), 32'(mDout));
    end
  end

  task automatic cyc(input logic [3:0] r);
    req = r;
    @(negedge clk);
  endtask

  task automatic doReset();
    req = 4'b0000;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [3:0] expG;
  logic [3:0] extra [11] = '{4'b1010, 4'b1010, 4'b0010, 4'b0110, 4'b0101, 4'b0101,
                             4'b0000, 4'b1100, 4'b1111, 4'b0001, 4'b0000};

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din0  = 4'hA;
    din1  = 4'h5;
    din2  = 4'hC;
    din3  = 4'h3;
    #12;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_select", 32'(select), 32'h0);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_valid", 32'(dout_valid), 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;

    // Single requester: grant after one edge, data after two.
    cyc(4'b0100);
    check("r2_grant", 32'(grant), 32'h4);
    check("r2_select", 32'(select), 32'h2);
    check("r2_valid_early", 32'(dout_valid), 32'h0);
    cyc(4'b0100);
    check("r2_dout", 32'(dout), 32'hC);
    check("r2_valid", 32'(dout_valid), 32'h1);
    cyc(4'b0000);
    check("r2_idle_grant", 32'(grant), 32'h0);
    check("r2_idle_valid", 32'(dout_valid), 32'h0);

    // Full rotation with each owner dropping for one cycle.
    doReset();
    cyc(4'b1111); check("rot_g0", 32'(grant), 32'h1);
    cyc(4'b1111); check("rot_g0_hold", 32'(grant), 32'h1);
    cyc(4'b1110); check("rot_g1", 32'(grant), 32'h2);
    cyc(4'b1111);
    cyc(4'b1101); check("rot_g2", 32'(grant), 32'h4);
    cyc(4'b1111);
    cyc(4'b1011); check("rot_g3", 32'(grant), 32'h8);
    cyc(4'b1111);
    cyc(4'b0111); check("rot_g0_again", 32'(grant), 32'h1);

    // Direct handover 1 -> 3 without an idle cycle, then idle.
    cyc(4'b0010); check("ho_g1", 32'(grant), 32'h2);
    cyc(4'b1011);
    cyc(4'b1001); check("ho_g3", 32'(grant), 32'h8);
    check("ho_sel3", 32'(select), 32'h3);
    cyc(4'b1001); check("ho_dout3", 32'(dout), 32'h3);
    check("ho_valid3", 32'(dout_valid), 32'h1);
    cyc(4'b0000); check("ho_idle", 32'(grant), 32'h0);
    check("ho_idle_valid", 32'(dout_valid), 32'h0);

    // Two persistent requesters, then a lone one.
    doReset();
    din0 = 4'h6;
    din1 = 4'h9;
    for (int k = 1; k <= 12; k++) begin
      cyc(4'b0011);
`ifdef ARB_TIMEOUT_EN
      expG = (((k - 1) / MAXT) % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      expG = 4'b0001;
`endif
      check("tenure_pair", 32'(grant), 32'(expG));
    end
    for (int k = 0; k < 8; k++) begin
      cyc(4'b0001);
      check("tenure_alone", 32'(grant), 32'h1);
    end
    check("tenure_alone_dout", 32'(dout), 32'h6);

    // Mixed patterns checked against the model only.
    for (int i = 0; i < 11; i++) begin
      din2 = 4'(i);
      cyc(extra[i]);
    end

    // Asynchronous reset in the middle of owner 2's tenure.
    doReset();
    din2 = 4'hE;
    cyc(4'b0100);
    cyc(4'b0100);
    check("ar_pre_valid", 32'(dout_valid), 32'h1);
    check("ar_pre_dout", 32'(dout), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(grant), 32'h0);
    check("ar_select", 32'(select), 32'h0);
    check("ar_dout", 32'(dout), 32'h0);
    check("ar_valid", 32'(dout_valid), 32'h0);
    #1 rst_n = 1'b1;
    req = 4'b1111;
    @(negedge clk);
    check("ar_first_grant", 32'(grant), 32'h1);
    cyc(4'b0000);
    cyc(4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

`default_nettype wire
